// File: rtl/ysyx_24080006_ifu_pfq.sv
// Instruction fetch unit with a prefetch queue.
// Streams sequential word fetches with several requests in flight, buffers the
// returned words, and aligns 16/32-bit instructions at any halfword boundary.
// A redirect flushes the queue and marks in-flight responses as stale.
module ysyx_24080006_ifu_pfq #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RST_ADDR        = 32'h3000_0000,
  parameter bit          ENABLE_C        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_is_zc,
  output logic        out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  entry_t           q_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outstanding;   // live requests whose words will be queued
  logic [OUT_W-1:0] drop_cnt;      // stale requests whose words will be discarded
  logic [31:0]      req_addr;
  logic [31:0]      pc;
  logic             hp;
  logic             halted;

  logic [SUM_W-1:0] occ_sum;
  logic [SUM_W-1:0] inflight;
  logic             req_fire;
  logic             rsp_stale;
  logic             q_push;
  entry_t           head;
  logic             has_h;
  logic             has_n;
  logic             lo_c;
  logic             hi_c;
  logic             pop_on_fire;
  logic             misalign;
  logic             out_fire;
  logic             do_pop;

  // Queue credit counts live requests; the memory limit counts every accepted
  // but unanswered request, stale ones included, so the port never sees more
  // than MAX_OUTSTANDING in flight even right after a redirect.
  assign occ_sum  = SUM_W'(count) + SUM_W'(outstanding);
  assign inflight = SUM_W'(outstanding) + SUM_W'(drop_cnt);

  assign mem_req_valid = !reset && !redirect_valid && !halted &&
                         (occ_sum < SUM_W'(DEPTH)) &&
                         (inflight < SUM_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = req_addr;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_stale = mem_rsp_valid && (drop_cnt != '0);
  assign q_push    = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid && !reset;

  assign rd_next = rd_ptr + PTR_W'(1);
  assign head    = q_mem[rd_ptr];
  assign has_h   = (count != '0);
  assign has_n   = (count > CNT_W'(1));
  assign lo_c    = ENABLE_C && (head.data[1:0] != 2'b11);
  assign hi_c    = ENABLE_C && (head.data[17:16] != 2'b11);

  assign out_pc   = pc;
  assign out_fire = out_valid && out_ready;
  assign do_pop   = out_fire && pop_on_fire;

  // Aligner: pick the instruction at the halfword pointer from the head word,
  // borrowing the low half of the next word when a 32-bit one straddles.
  // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    out_valid   = 1'b0;
    out_inst    = head.data;
    out_is_zc   = 1'b0;
    out_err     = head.err;
    pop_on_fire = 1'b0;
    misalign    = 1'b0;
    if (!hp) begin
      out_valid = has_h;
      if (lo_c) begin
        out_inst  = {16'b0, head.data[15:0]};
        out_is_zc = 1'b1;
      end else begin
        pop_on_fire = 1'b1;
      end
    end else if (!ENABLE_C) begin
      out_valid = has_h;
      out_err   = 1'b1;
      misalign  = 1'b1;
    end else if (hi_c) begin
      out_valid   = has_h;
      out_inst    = {16'b0, head.data[31:16]};
      out_is_zc   = 1'b1;
      pop_on_fire = 1'b1;
    end else begin
      out_valid   = has_n;
      out_inst    = {q_mem[rd_next].data[15:0], head.data[31:16]};
      out_err     = head.err | q_mem[rd_next].err;
      pop_on_fire = 1'b1;
    end
    if (reset || halted) out_valid = 1'b0;
  end

  // Queue storage: write the returned word at the tail.
  // NOTE: the storage array has no reset; occupancy is tracked by count, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (q_push) q_mem[wr_ptr] <= '{err: mem_rsp_err, data: mem_rsp_data};
  end

  // Control state: pointers, credits, fetch address, PC and halfword pointer.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_addr    <= {RST_ADDR[31:2], 2'b00};
      pc          <= RST_ADDR;
      hp          <= RST_ADDR[1];
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      // Everything in flight becomes stale; a response landing now is itself dropped.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= outstanding + drop_cnt - OUT_W'(mem_rsp_valid);
      req_addr    <= {redirect_pc[31:2], 2'b00};
      pc          <= redirect_pc & ~32'd1;
      hp          <= redirect_pc[1];
      halted      <= 1'b0;
    end else begin
      if (req_fire) req_addr <= req_addr + 32'd4;
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(q_push);
      if (rsp_stale) drop_cnt <= drop_cnt - OUT_W'(1);
      if (q_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_next;
      count <= count + CNT_W'(q_push) - CNT_W'(do_pop);
      if (out_fire) begin
        pc <= pc + (out_is_zc ? 32'd2 : 32'd4);
        if (!hp) hp <= lo_c;
        else if (hi_c) hp <= 1'b0;
        if (misalign) halted <= 1'b1;
      end
    end
  end

endmodule
